// File: rtl/spi_boot_pkg.sv
// Shared opcodes, FSM state encoding and default identity for the SPI boot responder.
package spi_boot_pkg;

  localparam logic [7:0]  OP_READ          = 8'h03;
  localparam logic [7:0]  OP_FAST_READ     = 8'h0B;
  localparam logic [7:0]  OP_RDSR          = 8'h05;
  localparam logic [7:0]  OP_RDID          = 8'h9F;
  localparam logic [23:0] DEFAULT_JEDEC_ID = 24'hEF4017;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_STAT,
    ST_ID,
    ST_IGNORE
  } state_t;

endpackage

// File: rtl/spi_boot_responder_if.sv
// Synchronous byte-memory read port between the responder (master) and the boot memory (slave).
interface spi_boot_responder_if #(
  parameter int ADDR_W = 19
);
  logic              mem_rd_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rd_data;

  modport master (output mem_rd_req, output mem_addr, input mem_rd_data);
  modport slave  (input mem_rd_req, input mem_addr, output mem_rd_data);
endinterface

// File: rtl/spi_pin_sync.sv
// Synchronizers and edge detectors for SCK, SS_N and MOSI in the system clock domain.
// SS_N falls are reported only after SS_N has been seen high following reset.
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sck,
  input  logic ss_n,
  input  logic mosi,
  output logic sck_rise,
  output logic sck_fall,
  output logic ss_fall,
  output logic ss_rise,
  output logic ss_sync,
  output logic mosi_sync
);
  logic [SYNC_STAGES-1:0] sck_q, ss_q, mosi_q;
  logic [SYNC_STAGES:0]   settle;
  logic                   sck_prev, ss_prev, ss_armed;

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_q    <= '0;
      ss_q     <= '1;
      mosi_q   <= '0;
      settle   <= '0;
      sck_prev <= 1'b0;
      ss_prev  <= 1'b1;
      ss_armed <= 1'b0;
    end else begin
      sck_q    <= {sck_q[SYNC_STAGES-2:0], sck};
      ss_q     <= {ss_q[SYNC_STAGES-2:0], ss_n};
      mosi_q   <= {mosi_q[SYNC_STAGES-2:0], mosi};
      settle   <= {settle[SYNC_STAGES-1:0], 1'b1};
      sck_prev <= sck_q[SYNC_STAGES-1];
      ss_prev  <= ss_q[SYNC_STAGES-1];
      // chain contents are only trusted once the reset value has been flushed out
      if (settle[SYNC_STAGES] && ss_prev) ss_armed <= 1'b1;
    end
  end

  assign sck_rise  = sck_q[SYNC_STAGES-1] & ~sck_prev;
  assign sck_fall  = ~sck_q[SYNC_STAGES-1] & sck_prev;
  assign ss_fall   = ss_armed & ss_prev & ~ss_q[SYNC_STAGES-1];
  assign ss_rise   = ss_q[SYNC_STAGES-1] & ~ss_prev;
  assign ss_sync   = ss_q[SYNC_STAGES-1];
  assign mosi_sync = mosi_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_boot_responder.sv
// SPI mode-0 boot-flash responder serving READ/RDSR/RDID from a synchronous byte memory.
// Defining SPI_RESP_FAST_READ_EN adds FAST READ (0x0B) with one dummy byte.
// IDLE wait SS_N | CMD opcode | ADDR 24-bit address | DUMMY fast-read pad
// DATA memory bytes | STAT status 00 | ID JEDEC bytes then 00 | IGNORE unsupported
module spi_boot_responder
  import spi_boot_pkg::*;
#(
  parameter int          ADDR_W      = 19,
  parameter logic [23:0] JEDEC_ID    = DEFAULT_JEDEC_ID,
  parameter int          SYNC_STAGES = 2
) (
  input  logic CLOCK,
  input  logic RESET,
  input  logic spi_sck,
  input  logic spi_ss_n,
  input  logic spi_mosi,
  output logic spi_miso,
  output logic spi_miso_oe,
  output logic busy,
  output logic cmd_err,
  spi_boot_responder_if.master mem
);
  logic              sck_rise, sck_fall, ss_fall, ss_rise, ss_sync, mosi_sync;
  state_t            state;
  logic [2:0]        bit_cnt, tx_cnt;
  logic [1:0]        byte_idx;
  logic [ADDR_W-2:0] sh;
  logic [ADDR_W-1:0] sh_next;
  logic [7:0]        tx_sh, prefetch, tx_next;
  logic              req_d, cap_to_tx;
`ifdef SPI_RESP_FAST_READ_EN
  logic              fast;
`endif

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_pin_sync (
    .clk      (CLOCK),
    .rst      (RESET),
    .sck      (spi_sck),
    .ss_n     (spi_ss_n),
    .mosi     (spi_mosi),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall),
    .ss_fall  (ss_fall),
    .ss_rise  (ss_rise),
    .ss_sync  (ss_sync),
    .mosi_sync(mosi_sync)
  );

  function automatic logic [7:0] id_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    id_byte = JEDEC_ID[23:16];
      2'd1:    id_byte = JEDEC_ID[15:8];
      2'd2:    id_byte = JEDEC_ID[7:0];
      default: id_byte = 8'h00;
    endcase
  endfunction

  assign sh_next = {sh, mosi_sync};

  always_comb begin
    tx_next = {tx_sh[6:0], 1'b0};
    if (tx_cnt == 3'd7) begin
      case (state)
        ST_DATA: tx_next = prefetch;
        ST_ID:   tx_next = id_byte(byte_idx);
        default: tx_next = 8'h00;
      endcase
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state          <= ST_IDLE;
      bit_cnt        <= '0;
      tx_cnt         <= '0;
      byte_idx       <= '0;
      sh             <= '0;
      tx_sh          <= '0;
      prefetch       <= '0;
      req_d          <= 1'b0;
      cap_to_tx      <= 1'b0;
      spi_miso       <= 1'b0;
      spi_miso_oe    <= 1'b0;
      busy           <= 1'b0;
      cmd_err        <= 1'b0;
      mem.mem_rd_req <= 1'b0;
      mem.mem_addr   <= '0;
`ifdef SPI_RESP_FAST_READ_EN
      fast           <= 1'b0;
`endif
    end else begin
      mem.mem_rd_req <= 1'b0;
      cmd_err        <= 1'b0;
      busy           <= ~ss_sync;
      req_d          <= mem.mem_rd_req;
      // deselect wins over any SCK edge seen in the same cycle
      if (ss_rise) begin
        state       <= ST_IDLE;
        spi_miso_oe <= 1'b0;
        spi_miso    <= 1'b0;
        bit_cnt     <= '0;
        req_d       <= 1'b0;
      end else if (ss_fall) begin
        state       <= ST_CMD;
        bit_cnt     <= '0;
        byte_idx    <= '0;
        spi_miso_oe <= 1'b0;
      end else begin
        if (req_d) begin
          if (cap_to_tx) tx_sh <= mem.mem_rd_data;
          else           prefetch <= mem.mem_rd_data;
        end
        if (sck_rise && state != ST_IDLE && state != ST_IGNORE) begin
          bit_cnt <= bit_cnt + 3'd1;
          sh      <= sh_next[ADDR_W-2:0];
        end
        case (state)
          ST_CMD: if (sck_rise && bit_cnt == 3'd7) begin
            case (sh_next[7:0])
              OP_READ: begin
                state    <= ST_ADDR;
                byte_idx <= '0;
`ifdef SPI_RESP_FAST_READ_EN
                fast     <= 1'b0;
              end
              OP_FAST_READ: begin
                state    <= ST_ADDR;
                byte_idx <= '0;
                fast     <= 1'b1;
`endif
              end
              OP_RDSR: begin
                state       <= ST_STAT;
                tx_sh       <= 8'h00;
                tx_cnt      <= '0;
                spi_miso_oe <= 1'b1;
              end
              OP_RDID: begin
                state       <= ST_ID;
                tx_sh       <= id_byte(2'd0);
                byte_idx    <= 2'd1;
                tx_cnt      <= '0;
                spi_miso_oe <= 1'b1;
              end
              default: begin
                state   <= ST_IGNORE;
                cmd_err <= 1'b1;
              end
            endcase
          end
          ST_ADDR: if (sck_rise && bit_cnt == 3'd7) begin
            if (byte_idx == 2'd2) begin
              mem.mem_addr   <= sh_next;
              mem.mem_rd_req <= 1'b1;
              cap_to_tx      <= 1'b1;
`ifdef SPI_RESP_FAST_READ_EN
              if (fast) begin
                state <= ST_DUMMY;
              end else begin
                state       <= ST_DATA;
                spi_miso_oe <= 1'b1;
                tx_cnt      <= '0;
              end
`else
              state       <= ST_DATA;
              spi_miso_oe <= 1'b1;
              tx_cnt      <= '0;
`endif
            end else begin
              byte_idx <= byte_idx + 2'd1;
            end
          end
`ifdef SPI_RESP_FAST_READ_EN
          ST_DUMMY: if (sck_rise && bit_cnt == 3'd7) begin
            state       <= ST_DATA;
            spi_miso_oe <= 1'b1;
            tx_cnt      <= '0;
          end
`endif
          ST_DATA, ST_STAT, ST_ID: begin
            if (state == ST_DATA && sck_rise && bit_cnt == 3'd0) begin
              mem.mem_addr   <= mem.mem_addr + ADDR_W'(1);
              mem.mem_rd_req <= 1'b1;
              cap_to_tx      <= 1'b0;
            end
            if (sck_fall) begin
              spi_miso <= tx_sh[7];
              tx_sh    <= tx_next;
              tx_cnt   <= tx_cnt + 3'd1;
              if (state == ST_ID && tx_cnt == 3'd7 && byte_idx != 2'd3)
                byte_idx <= byte_idx + 2'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
